fb_port2_arbiter: RTL and testbench
===================================

Name: fb_port2_arbiter

Overview:
- Owns the second port of the 640x480x8 on-chip frame-buffer RAM: 19-bit address, 8-bit data, registered address, unregistered output, one-cycle read latency.
- Shares that port among three requesters in a single clock domain, in priority order:
  - the video scan-out reader;
  - a host Avalon-MM master;
  - a built-in fill/clear engine.
- Adds starvation protection for the host, and a read-data return path that routes each read result back to its issuer.

Parameters:
- ADDR_W, 19, RAM address width.
- DATA_W, 8, RAM data width.
- DEPTH, 307200, number of valid RAM words.
- STARVE_LIMIT, 16, consecutive denied host cycles before the host is forced a slot.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- vid_req  in  1  scan-out read request.
- vid_addr  in  ADDR_W  scan-out read address.
- vid_gnt  out  1  scan-out read issued this cycle (combinational).
- vid_rdata  out  DATA_W  scan-out read data.
- vid_rvalid  out  1  vid_rdata valid.
- host_address  in  ADDR_W  Avalon word address.
- host_read  in  1  Avalon read.
- host_write  in  1  Avalon write.
- host_writedata  in  DATA_W  Avalon write data.
- host_waitrequest  out  1  Avalon stall (combinational).
- host_readdata  out  DATA_W  Avalon read data.
- host_readdatavalid  out  1  Avalon read data valid.
- clr_start  in  1  pulse that starts a fill.
- clr_base  in  ADDR_W  first fill address.
- clr_count  in  ADDR_W  number of words to fill.
- clr_value  in  DATA_W  fill byte.
- clr_busy  out  1  fill in progress.
- clr_done  out  1  one-cycle pulse when a fill completes.
- ram_address  out  ADDR_W  to RAM port 2.
- ram_chipselect  out  1  to RAM port 2.
- ram_write  out  1  to RAM port 2.
- ram_writedata  out  DATA_W  to RAM port 2.
- ram_clken  out  1  to RAM port 2; constant 1.
- ram_readdata  in  DATA_W  from RAM port 2.

Behaviour:
- Reset values (reset_n low at a clk edge):
  - all flops cleared;
  - clr_busy=0, clr_done=0, vid_rvalid=0, host_readdatavalid=0, starvation counter=0;
  - ram_chipselect=0, ram_write=0;
  - a fill in flight is aborted with no clr_done;
  - read-return tags are cleared, so no stale rvalid appears after reset.
- One grant per cycle; all grant logic is combinational from the current-cycle requests.
- Priority and grant rules:
  - Default order is video > host > clear.
  - When starve_cnt==STARVE_LIMIT and the host is requesting, the host wins and vid_gnt=0 that cycle.
  - host_waitrequest = host request present AND host not granted.
  - A host request is host_read|host_write; if both are high, the write wins.
- Starvation counter:
  - increments on each cycle the host requests and is denied;
  - saturates at STARVE_LIMIT;
  - clears on a host grant or when the host is idle.
- RAM drive: the granted request drives ram_* in the same cycle with ram_chipselect=1. ram_write=1 only for a granted host write or a clear write.
- Read return path:
  - A registered 2-bit tag records the owner of a granted read (video or host).
  - In the next cycle, ram_readdata is routed to that owner with its valid flag high; the other valid flag stays 0.
  - Back-to-back reads sustain 1 word/cycle.
- Out-of-range host access (host_address >= DEPTH):
  - granted normally, but ram_chipselect=0;
  - a write is dropped;
  - a read returns readdatavalid one cycle later with readdata=0.
- Video addresses are trusted to be in range.
- Fill engine FSM, states IDLE, RUN, DONE:
  - IDLE: on clr_start, latch base, value and eff_count = min(clr_count, DEPTH-clr_base); go to RUN.
    - If eff_count==0 or clr_base>=DEPTH: go straight to DONE.
  - RUN: issue one write whenever granted; advance the address and decrement the remaining count on each grant. When the last write is granted, go to DONE.
  - DONE: pulse clr_done for one cycle; return to IDLE.
  - clr_busy=1 in RUN and DONE.
  - clr_start while busy is ignored.
- Simultaneous events:
  - A host write and a fill write to the same address: the host write is granted first, the fill overwrites it later; this ordering is accepted.
  - Video and host requesting in the same cycle with starve_cnt<STARVE_LIMIT: video wins.

Decomposition:
- Shared package fb_pkg:
  - FB_ADDR_W=19, FB_DATA_W=8, FB_DEPTH=307200;
  - enum of owner tags {OWN_NONE, OWN_VID, OWN_HOST};
  - enum of clear FSM states.
- Sub-module fb_clear_engine:
  - contains the fill FSM, the address/count registers and the range clamp;
  - exposes a req/addr/data/gnt interface to the arbiter core.

Test Plan:
- Host-only read: RAM[5]=0xA5, host_read with address 5 → waitrequest=0 that cycle; next cycle readdatavalid=1, readdata=0xA5.
- Starvation, STARVE_LIMIT=4: vid_req held high continuously, host_write to address 10 with data 0x55 → waitrequest high for 4 cycles. On the 5th cycle: host granted, vid_gnt=0, RAM[10]=0x55. Video resumes the following cycle.
- Fill: base=100, count=3, value=0x3C with no other traffic → writes to 100, 101, 102 on 3 consecutive cycles; clr_done pulses on the next cycle. Host reads of 100..102 return 0x3C; 103 is unchanged.
- Clamp and out-of-range:
  - fill with base=307198, count=10 → exactly 2 writes, then done.
  - host read at 307200 → readdatavalid with 0x00 and ram_chipselect never asserted.
- Reset mid-fill: reset_n low after the 2nd of 5 writes → clr_busy=0 next cycle, no clr_done, no further RAM writes. clr_start while busy is ignored (count unchanged).
- Interleaved reads: alternating video/host reads on consecutive cycles → each rdata is returned only on its issuer's valid, with exactly 1-cycle latency.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and enums for the frame-buffer port-2 arbiter.
// Owner tags route one-cycle-late read data back to its issuer.
package fb_pkg;
    localparam int FB_ADDR_W = 19;
    localparam int FB_DATA_W = 8;
    localparam int FB_DEPTH  = 307200;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_HOST = 2'd2
    } own_e;

    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_RUN  = 2'd1,
        CLR_DONE = 2'd2
    } clr_state_e;
endpackage

// File: rtl/fb_clear_engine.sv
// Fill/clear engine: writes a byte over a clamped address range,
// one word per granted cycle, then pulses done.
import fb_pkg::*;

module fb_clear_engine #(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W,
    parameter int DEPTH  = FB_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W-1:0] i_count,
    input  logic [DATA_W-1:0] i_value,
    output logic              o_req,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_gnt,
    output logic              o_busy,
    output logic              o_done
);
    localparam logic [1:0] ST_IDLE = CLR_IDLE;
    localparam logic [1:0] ST_RUN  = CLR_RUN;
    localparam logic [1:0] ST_DONE = CLR_DONE;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_left;
    logic [DATA_W-1:0] r_value;

    logic [ADDR_W:0] w_room;
    logic [ADDR_W:0] w_eff;
    logic            w_in_range;

    // Room left before the end of RAM; only meaningful when base is in range
    assign w_room     = DEPTH_L - {1'b0, i_base};
    assign w_in_range = {1'b0, i_base} < DEPTH_L;
    assign w_eff      = ({1'b0, i_count} < w_room) ? {1'b0, i_count} : w_room;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_left  <= '0;
            r_value <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_addr  <= i_base;
                        r_value <= i_value;
                        r_left  <= w_eff[ADDR_W-1:0];
                        if (!w_in_range || w_eff == '0)
                            r_state <= ST_DONE;
                        else
                            r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_gnt) begin
                        r_addr <= r_addr + 1'b1;
                        r_left <= r_left - 1'b1;
                        if (r_left == ADDR_W'(1))
                            r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_req  = (r_state == ST_RUN);
    assign o_addr = r_addr;
    assign o_data = r_value;
    assign o_busy = (r_state != ST_IDLE);
    assign o_done = (r_state == ST_DONE);
endmodule

// File: rtl/fb_port2_arbiter.sv
// Frame-buffer RAM port-2 arbiter: video > host > fill, with host
// starvation relief and a tagged one-cycle read-return path.
import fb_pkg::*;

module fb_port2_arbiter #(
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int DATA_W       = FB_DATA_W,
    parameter int DEPTH        = FB_DEPTH,
    parameter int STARVE_LIMIT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    input  logic [ADDR_W-1:0] host_address,
    input  logic              host_read,
    input  logic              host_write,
    input  logic [DATA_W-1:0] host_writedata,
    output logic              host_waitrequest,
    output logic [DATA_W-1:0] host_readdata,
    output logic              host_readdatavalid,
    input  logic              clr_start,
    input  logic [ADDR_W-1:0] clr_base,
    input  logic [ADDR_W-1:0] clr_count,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [CNT_W-1:0] r_starve;
    own_e             r_tag;
    logic             r_zero;

    logic              w_host_req;
    logic              w_host_oor;
    logic              w_force;
    logic              w_gnt_vid;
    logic              w_gnt_host;
    logic              w_gnt_clr;
    logic              w_clr_req;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [DATA_W-1:0] w_clr_data;

    fb_clear_engine #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_clr (
        .clk    (clk),
        .reset_n(reset_n),
        .i_start(clr_start),
        .i_base (clr_base),
        .i_count(clr_count),
        .i_value(clr_value),
        .o_req  (w_clr_req),
        .o_addr (w_clr_addr),
        .o_data (w_clr_data),
        .i_gnt  (w_gnt_clr),
        .o_busy (clr_busy),
        .o_done (clr_done)
    );

    assign w_host_req = host_read | host_write;
    assign w_host_oor = {1'b0, host_address} >= DEPTH_L;
    assign w_force    = w_host_req && (r_starve == LIMIT);

    // No grants while reset is asserted so an aborted fill writes nothing
    assign w_gnt_vid  = reset_n && vid_req && !w_force;
    assign w_gnt_host = reset_n && w_host_req && !w_gnt_vid;
    assign w_gnt_clr  = reset_n && w_clr_req && !vid_req && !w_host_req;

    assign vid_gnt          = w_gnt_vid;
    assign host_waitrequest = w_host_req && !w_gnt_host;
    assign ram_clken        = 1'b1;

    always_comb begin
        ram_address    = '0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_writedata  = '0;
        unique case (1'b1)
            w_gnt_vid: begin
                ram_address    = vid_addr;
                ram_chipselect = 1'b1;
            end
            w_gnt_host: begin
                ram_address    = host_address;
                ram_chipselect = !w_host_oor;
                ram_write      = host_write && !w_host_oor;
                ram_writedata  = host_writedata;
            end
            w_gnt_clr: begin
                ram_address    = w_clr_addr;
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_writedata  = w_clr_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_starve <= '0;
            r_tag    <= OWN_NONE;
            r_zero   <= 1'b0;
        end else begin
            if (w_host_req && !w_gnt_host) begin
                if (r_starve != LIMIT)
                    r_starve <= r_starve + 1'b1;
            end else begin
                r_starve <= '0;
            end
            if (w_gnt_vid)
                r_tag <= OWN_VID;
            else if (w_gnt_host && !host_write)
                r_tag <= OWN_HOST;
            else
                r_tag <= OWN_NONE;
            r_zero <= w_host_oor;
        end
    end

    assign vid_rvalid         = (r_tag == OWN_VID);
    assign vid_rdata          = ram_readdata;
    assign host_readdatavalid = (r_tag == OWN_HOST);
    assign host_readdata      = r_zero ? '0 : ram_readdata;
endmodule

// File: tb/tb_fb_port2_arbiter.sv
// Randomized and directed bench for fb_port2_arbiter against a
// cycle-level behavioural model of the arbitration rules.
module tb_fb_port2_arbiter;
    localparam int AW = 19;
    localparam int DW = 8;
    localparam int DEPTH = 307200;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          vid_req = 1'b0;
    logic [AW-1:0] vid_addr = '0;
    logic          vid_gnt;
    logic [DW-1:0] vid_rdata;
    logic          vid_rvalid;
    logic [AW-1:0] host_address = '0;
    logic          host_read = 1'b0;
    logic          host_write = 1'b0;
    logic [DW-1:0] host_writedata = '0;
    logic          host_waitrequest;
    logic [DW-1:0] host_readdata;
    logic          host_readdatavalid;
    logic          clr_start = 1'b0;
    logic [AW-1:0] clr_base = '0;
    logic [AW-1:0] clr_count = '0;
    logic [DW-1:0] clr_value = '0;
    logic          clr_busy;
    logic          clr_done;
    logic [AW-1:0] ram_address;
    logic          ram_chipselect;
    logic          ram_write;
    logic [DW-1:0] ram_writedata;
    logic          ram_clken;
    logic [DW-1:0] ram_readdata;

    fb_port2_arbiter #(.STARVE_LIMIT(SL)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .vid_req           (vid_req),
        .vid_addr          (vid_addr),
        .vid_gnt           (vid_gnt),
        .vid_rdata         (vid_rdata),
        .vid_rvalid        (vid_rvalid),
        .host_address      (host_address),
        .host_read         (host_read),
        .host_write        (host_write),
        .host_writedata    (host_writedata),
        .host_waitrequest  (host_waitrequest),
        .host_readdata     (host_readdata),
        .host_readdatavalid(host_readdatavalid),
        .clr_start         (clr_start),
        .clr_base          (clr_base),
        .clr_count         (clr_count),
        .clr_value         (clr_value),
        .clr_busy          (clr_busy),
        .clr_done          (clr_done),
        .ram_address       (ram_address),
        .ram_chipselect    (ram_chipselect),
        .ram_write         (ram_write),
        .ram_writedata     (ram_writedata),
        .ram_clken         (ram_clken),
        .ram_readdata      (ram_readdata)
    );

    always #5 clk = ~clk;

    // RAM: registered address, unregistered output
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] raddr = '0;
    always @(posedge clk) begin
        if (ram_chipselect && ram_clken) begin
            if (ram_write) mem[ram_address] <= ram_writedata;
            raddr <= ram_address;
        end
    end
    assign ram_readdata = mem[raddr];

    // Reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    int  m_starve = 0;
    bit  m_known = 0;
    int  m_pend = 0;
    logic [DW-1:0] m_pdata = '0;
    bit  m_run = 0;
    bit  m_done = 0;
    int  m_addr = 0;
    int  m_left = 0;
    logic [DW-1:0] m_val = '0;

    int n_chk = 0;
    int n_err = 0;
    int n_wr = 0;
    int n_wait = 0;
    logic [DW-1:0] last_hrd = '0;

    function automatic logic [DW-1:0] init_val(int a);
        return (a == 5) ? 8'hA5 : 8'(a * 37 + 11);
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step();
        bit hreq, fh, gv, gh, gc, oor, cs, wr, busy_now, dnx;
        int ha, room, eff;
        @(negedge clk);
        hreq = host_read || host_write;
        ha   = int'(host_address);
        oor  = ha >= DEPTH;
        if (m_known) begin
            check("vid_rvalid", 32'(vid_rvalid), 32'(m_pend == 1));
            check("host_rdv", 32'(host_readdatavalid), 32'(m_pend == 2));
            if (m_pend == 1) check("vid_rdata", 32'(vid_rdata), 32'(m_pdata));
            if (m_pend == 2) begin
                check("host_rdata", 32'(host_readdata), 32'(m_pdata));
                last_hrd = host_readdata;
            end
            check("clr_done", 32'(clr_done), 32'(m_done));
            check("clr_busy", 32'(clr_busy), 32'(m_run || m_done));
        end
        fh = hreq && (m_starve >= SL);
        gv = reset_n && vid_req && !fh;
        gh = reset_n && hreq && !gv;
        gc = reset_n && m_run && !vid_req && !hreq;
        check("vid_gnt", 32'(vid_gnt), 32'(gv));
        check("waitreq", 32'(host_waitrequest), 32'(hreq && !gh));
        if (host_waitrequest) n_wait++;
        if (ram_chipselect && ram_write) n_wr++;
        if (m_known) begin
            cs = gv || gc || (gh && !oor);
            wr = gc || (gh && host_write && !oor);
            check("ram_cs", 32'(ram_chipselect), 32'(cs));
            if (cs) begin
                check("ram_we", 32'(ram_write), 32'(wr));
                check("ram_addr", 32'(ram_address),
                      gv ? 32'(vid_addr) : gh ? 32'(ha) : 32'(m_addr));
            end
            if (wr)
                check("ram_wdata", 32'(ram_writedata),
                      gh ? 32'(host_writedata) : 32'(m_val));
        end
        if (!reset_n) begin
            m_known = 1;
            m_pend = 0;
            m_starve = 0;
            m_run = 0;
            m_done = 0;
        end else begin
            busy_now = m_run || m_done;
            m_pend = 0;
            if (gv) begin
                m_pend = 1;
                m_pdata = ref_mem[int'(vid_addr)];
            end else if (gh && !host_write) begin
                m_pend = 2;
                m_pdata = oor ? 8'h00 : ref_mem[ha];
            end
            if (gh && host_write && !oor) ref_mem[ha] = host_writedata;
            m_starve = (hreq && !gh) ?
                       ((m_starve < SL) ? m_starve + 1 : SL) : 0;
            dnx = 0;
            if (gc) begin
                ref_mem[m_addr] = m_val;
                m_addr++;
                m_left--;
                if (m_left == 0) begin
                    m_run = 0;
                    dnx = 1;
                end
            end
            if (clr_start && !busy_now) begin
                if (int'(clr_base) >= DEPTH) begin
                    dnx = 1;
                end else begin
                    room = DEPTH - int'(clr_base);
                    eff = (int'(clr_count) < room) ? int'(clr_count) : room;
                    if (eff == 0) begin
                        dnx = 1;
                    end else begin
                        m_run = 1;
                        m_addr = int'(clr_base);
                        m_left = eff;
                        m_val = clr_value;
                    end
                end
            end
            m_done = dnx;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vid_req = 0;
        host_read = 0;
        host_write = 0;
        clr_start = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic fill(input int base, input int cnt, input logic [7:0] v);
        clr_start = 1;
        clr_base = AW'(base);
        clr_count = AW'(cnt);
        clr_value = v;
        step();
        clr_start = 0;
    endtask

    int w0, k;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= init_val(i);
            ref_mem[i] = init_val(i);
        end
        #1;
        reset_n = 0;
        step();
        step();
        reset_n = 1;
        step();

        // Host-only read
        host_read = 1;
        host_address = 5;
        step();
        host_read = 0;
        step();
        check("host_rd5", 32'(last_hrd), 32'hA5);

        // Starvation relief
        vid_req = 1;
        vid_addr = 20;
        host_write = 1;
        host_address = 10;
        host_writedata = 8'h55;
        w0 = n_wait;
        for (int i = 0; i < SL + 1; i++) step();
        host_write = 0;
        step();
        step();
        check("starve_wait", 32'(n_wait - w0), 32'(SL));
        check("starve_mem10", 32'(mem[10]), 32'h55);
        idle(2);

        // Plain fill
        w0 = n_wr;
        fill(100, 3, 8'h3C);
        idle(6);
        check("fill_writes", 32'(n_wr - w0), 32'd3);
        for (int a = 100; a < 104; a++)
            check("fill_mem", 32'(mem[a]), a < 103 ? 32'h3C : 32'(init_val(a)));
        for (int a = 100; a < 104; a++) begin
            host_read = 1;
            host_address = AW'(a);
            step();
            host_read = 0;
            step();
            check("fill_rd", 32'(last_hrd),
                  a < 103 ? 32'h3C : 32'(init_val(a)));
        end

        // Clamp at end of RAM, then out-of-range read
        w0 = n_wr;
        fill(307198, 10, 8'h77);
        idle(6);
        check("clamp_writes", 32'(n_wr - w0), 32'd2);
        last_hrd = 8'hFF;
        host_read = 1;
        host_address = AW'(307200);
        step();
        host_read = 0;
        step();
        check("oor_rd", 32'(last_hrd), 32'h00);

        // Reset in the middle of a fill
        w0 = n_wr;
        fill(200, 5, 8'h99);
        step();
        step();
        reset_n = 0;
        step();
        reset_n = 1;
        idle(6);
        check("rst_writes", 32'(n_wr - w0), 32'd2);
        check("rst_mem202", 32'(mem[202]), 32'(init_val(202)));

        // Start while busy is ignored
        w0 = n_wr;
        fill(300, 4, 8'h11);
        fill(400, 1, 8'h22);
        idle(6);
        check("busy_writes", 32'(n_wr - w0), 32'd4);
        check("busy_mem400", 32'(mem[400]), 32'(init_val(400)));

        // Alternating video/host reads
        for (int i = 0; i < 8; i++) begin
            vid_req = (i % 2) == 0;
            host_read = (i % 2) == 1;
            vid_addr = AW'(100 + i);
            host_address = AW'(i);
            step();
        end
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            k = int'($urandom % 8);
            vid_req = ($urandom % 5) < 2;
            vid_addr = AW'($urandom % 64);
            host_read = (k == 1) || (k == 2) || (k == 7);
            host_write = (k == 3) || (k == 4) || (k == 7);
            host_address = ($urandom % 8 == 0) ?
                           AW'(307190 + $urandom % 20) : AW'($urandom % 64);
            host_writedata = 8'($urandom);
            clr_start = ($urandom % 32) == 0;
            clr_base = ($urandom % 4 == 0) ?
                       AW'(307195 + $urandom % 10) : AW'($urandom % 60);
            clr_count = AW'($urandom % 9);
            clr_value = 8'($urandom);
            step();
        end
        idle(12);
        for (int a = 0; a < 72; a++)
            check("mem_lo", 32'(mem[a]), 32'(ref_mem[a]));
        for (int a = 307190; a < DEPTH; a++)
            check("mem_hi", 32'(mem[a]), 32'(ref_mem[a]));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
